// File: rtl/cordic_pkg.sv
// Shared constants and quadrant codes for the CORDIC back end.
package cordic_pkg;

   localparam int DATA_W     = 32;
   localparam int FRAC_BITS  = 30;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 16;

   // 1/An for the iteration count used upstream, Q2.30
   localparam logic [31:0] CORDIC_GAIN_Q30 = 32'h26DD3B6A;

   typedef enum logic [1:0] {
      QUAD_NONE = 2'b00,
      QUAD_P90  = 2'b01,
      QUAD_M90  = 2'b10,
      QUAD_180  = 2'b11
   } quad_t;

endpackage

// File: rtl/cordic_out_fifo.sv
// First-word-fall-through FIFO; the head entry is always visible on rdata.
module cordic_out_fifo #(
   parameter int DW    = 96,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DW-1:0]          wdata,
   output logic [DW-1:0]          rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   import cordic_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Storage is cleared too so the data outputs read zero out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/cordic_output_stage.sv
// CORDIC back end: gain removal, quadrant un-rotation and a buffered valid/ready
// output that drops and counts samples when the consumer stalls.
module cordic_output_stage #(
   parameter int DATA_W     = cordic_pkg::DATA_W,
   parameter int FRAC_BITS  = cordic_pkg::FRAC_BITS,
   parameter int FIFO_DEPTH = cordic_pkg::FIFO_DEPTH,
   parameter int CNT_W      = cordic_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] x_in,
   input  logic [DATA_W-1:0] y_in,
   input  logic [DATA_W-1:0] z_in,
   input  logic [1:0]        quad_in,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] cos_out,
   output logic [DATA_W-1:0] sin_out,
   output logic [DATA_W-1:0] z_out,
   output logic              almost_full,
   output logic              overflow,
   output logic [CNT_W-1:0]  drop_count
);
   import cordic_pkg::*;

   localparam int PW = 2 * DATA_W;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic signed [PW-1:0] GAIN = PW'($signed(CORDIC_GAIN_Q30));
   localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC_BITS - 1);

   // K < 1, so the rounded product always fits back into DATA_W
   function automatic logic [DATA_W-1:0] gain_scale(input logic [DATA_W-1:0] v);
      logic signed [PW-1:0] p;
      p = PW'($signed(v)) * GAIN + HALF;
      return DATA_W'(p >>> FRAC_BITS);
   endfunction

   logic              s1_valid;
   logic [DATA_W-1:0] s1_x;
   logic [DATA_W-1:0] s1_y;
   logic [DATA_W-1:0] s1_z;
   quad_t             s1_quad;

   logic              s2_valid;
   logic [DATA_W-1:0] s2_cos;
   logic [DATA_W-1:0] s2_sin;
   logic [DATA_W-1:0] s2_z;

   logic [DATA_W-1:0] rot_c;
   logic [DATA_W-1:0] rot_s;

   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       occupancy;
   logic              pop;
   logic              push;
   logic              drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_z     <= '0;
         s1_quad  <= QUAD_NONE;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_x    <= gain_scale(x_in);
            s1_y    <= gain_scale(y_in);
            s1_z    <= z_in;
            s1_quad <= quad_t'(quad_in);
         end
      end
   end

   // Undo the upstream pre-rotation; scaled operands never reach -2^(DATA_W-1)
   always_comb begin
      rot_c = s1_x;
      rot_s = s1_y;
      case (s1_quad)
         QUAD_P90: begin
            rot_c = -s1_y;
            rot_s = s1_x;
         end
         QUAD_M90: begin
            rot_c = s1_y;
            rot_s = -s1_x;
         end
         QUAD_180: begin
            rot_c = -s1_x;
            rot_s = -s1_y;
         end
         default: begin
            rot_c = s1_x;
            rot_s = s1_y;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_cos   <= '0;
         s2_sin   <= '0;
         s2_z     <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_cos <= rot_c;
            s2_sin <= rot_s;
            s2_z   <= s1_z;
         end
      end
   end

   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign push      = s2_valid && (!fifo_full || pop);
   assign drop      = s2_valid && fifo_full && !pop;

   cordic_out_fifo #(
      .DW    (3 * DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({s2_z, s2_sin, s2_cos}),
      .rdata ({z_out, sin_out, cos_out}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Counts samples already committed upstream so the producer can stop in time
   assign occupancy   = {1'b0, fifo_count} + (CW+1)'(s1_valid) + (CW+1)'(s2_valid);
   assign almost_full = (occupancy >= (CW+1)'(FIFO_DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_cordic_output_stage.sv
// Directed bench for cordic_output_stage; expected results go into a scoreboard
// queue at issue time and a negedge monitor checks each accepted output.
module tb_cordic_output_stage;

   localparam logic [31:0] K  = 32'h26DD3B6A;
   localparam logic [31:0] NK = 32'hD922C496;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] x_in;
   logic [31:0] y_in;
   logic [31:0] z_in;
   logic [1:0]  quad_in;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] cos_out;
   logic [31:0] sin_out;
   logic [31:0] z_out;
   logic        almost_full;
   logic        overflow;
   logic [15:0] drop_count;

   typedef struct {
      logic [31:0] c;
      logic [31:0] s;
      logic [31:0] z;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cordic_output_stage dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .x_in        (x_in),
      .y_in        (y_in),
      .z_in        (z_in),
      .quad_in     (quad_in),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .cos_out     (cos_out),
      .sin_out     (sin_out),
      .z_out       (z_out),
      .almost_full (almost_full),
      .overflow    (overflow),
      .drop_count  (drop_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                        input logic [1:0] q, input logic [31:0] ec, input logic [31:0] es,
                        input bit keep);
      exp_t e;
      x_in     = x;
      y_in     = y;
      z_in     = z;
      quad_in  = q;
      in_valid = 1'b1;
      if (keep) begin
         e.c = ec;
         e.s = es;
         e.z = z;
         sb.push_back(e);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) begin
         checks++;
         errors++;
         $display("FAIL %s drain timeout, pending=%0d out_valid=%0b", name, sb.size(), out_valid);
      end
   endtask

   // Issued sample must surface exactly 3 edges after it is sampled
   task automatic latency_probe(input string name, input logic [31:0] x, input logic [31:0] z,
                                input logic [31:0] ec);
      issue(x, 32'h0, z, 2'b00, ec, 32'h0, 1'b1);
      tick();
      chk({name, "_valid_at_2"}, 32'(out_valid), 32'd0);
      tick();
      chk({name, "_valid_at_3"}, 32'(out_valid), 32'd1);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual cos=%h sin=%h z=%h required none",
                     cos_out, sin_out, z_out);
         end else begin
            e = sb.pop_front();
            chk("cos_out", cos_out, e.c);
            chk("sin_out", sin_out, e.s);
            chk("z_out",   z_out,   e.z);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Expected (cos,sin) for x=1.0,y=0 under each quadrant code
   logic [31:0] qc [4];
   logic [31:0] qs [4];

   initial begin
      qc[0] = K;     qs[0] = 32'h0;
      qc[1] = 32'h0; qs[1] = K;
      qc[2] = 32'h0; qs[2] = NK;
      qc[3] = NK;    qs[3] = 32'h0;

      rst = 1'b1; in_valid = 1'b0; x_in = '0; y_in = '0; z_in = '0; quad_in = '0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_out_valid",   32'(out_valid),   32'd0);
      chk("rst_cos",         cos_out,          32'd0);
      chk("rst_sin",         sin_out,          32'd0);
      chk("rst_z",           z_out,            32'd0);
      chk("rst_almost_full", 32'(almost_full), 32'd0);
      chk("rst_overflow",    32'(overflow),    32'd0);
      chk("rst_drop_count",  32'(drop_count),  32'd0);
      rst = 1'b0;
      tick();

      // Unity input, no rotation, with latency check
      latency_probe("lat1", 32'h40000000, 32'h0000ABCD, K);
      wait_drain("t1");

      // Quadrant corrections
      for (int q = 1; q < 4; q++)
         issue(32'h40000000, 32'h0, 32'h100 + 32'(q), 2'(q), qc[q], qs[q], 1'b1);
      issue(32'h20000000, 32'hC0000000, 32'h111, 2'b00, 32'h136E9DB5, NK, 1'b1);
      issue(32'h20000000, 32'hC0000000, 32'h112, 2'b01, K, 32'h136E9DB5, 1'b1);
      wait_drain("t2");

      // Rounding at the smallest magnitudes
      issue(32'h00000001, 32'h0,        32'h201, 2'b00, 32'h1,        32'h0, 1'b1);
      issue(32'hFFFFFFFF, 32'h0,        32'h202, 2'b00, 32'hFFFFFFFF, 32'h0, 1'b1);
      issue(32'h0,        32'h00000001, 32'h203, 2'b00, 32'h0,        32'h1, 1'b1);
      issue(32'h00000002, 32'h0,        32'h204, 2'b00, 32'h1,        32'h0, 1'b1);
      wait_drain("t3");

      // Stalled consumer: six back-to-back, last two dropped
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++)
         issue(32'h40000000, 32'h0, 32'h300 + 32'(i), 2'(i % 4), qc[i % 4], qs[i % 4], i < 4);
      tick(); tick(); tick();
      chk("stall_overflow",    32'(overflow),    32'd1);
      chk("stall_drop_count",  32'(drop_count),  32'd2);
      chk("stall_almost_full", 32'(almost_full), 32'd1);
      chk("stall_head_cos",    cos_out,          K);
      chk("stall_head_z",      z_out,            32'h300);
      tick();
      chk("stall_head_hold_z", z_out,            32'h300);
      out_ready = 1'b1;
      wait_drain("t4");
      chk("drained_valid",       32'(out_valid),   32'd0);
      chk("drained_almost_full", 32'(almost_full), 32'd0);

      // Full FIFO, pop and push in the same cycle
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         issue(32'h40000000, 32'h0, 32'h400 + 32'(i), 2'b00, K, 32'h0, 1'b1);
      tick(); tick();
      chk("full_almost_full", 32'(almost_full), 32'd1);
      issue(32'h40000000, 32'h0, 32'h404, 2'b11, NK, 32'h0, 1'b1);
      tick();
      out_ready = 1'b1;
      tick();
      chk("popush_drop_count",  32'(drop_count),  32'd2);
      chk("popush_almost_full", 32'(almost_full), 32'd1);
      wait_drain("t5");

      // Reset with two in flight and three queued
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         issue(32'h40000000, 32'h0, 32'h500 + 32'(i), 2'b00, K, 32'h0, 1'b1);
      tick(); tick();
      issue(32'h40000000, 32'h0, 32'h503, 2'b00, K, 32'h0, 1'b0);
      issue(32'h40000000, 32'h0, 32'h504, 2'b00, K, 32'h0, 1'b0);
      rst = 1'b1;
      tick();
      chk("rst2_out_valid",   32'(out_valid),   32'd0);
      chk("rst2_drop_count",  32'(drop_count),  32'd0);
      chk("rst2_overflow",    32'(overflow),    32'd0);
      chk("rst2_almost_full", 32'(almost_full), 32'd0);
      sb.delete();
      rst = 1'b0;
      out_ready = 1'b1;
      latency_probe("lat2", 32'hFFFFFFFF, 32'h0000600D, 32'hFFFFFFFF);
      wait_drain("t6");

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
